// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment BCD controller.
package seg7_pkg;

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned MAX_DEC = 9999;
  localparam logic [BCD_W-1:0] SAT_BCD = 16'h9999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/seg7_bcd_ctrl.sv
// Multi-cycle binary-to-BCD converter with valid/ready input and a held, saturating
// four-digit BCD output for the seven-segment decoder.
module seg7_bcd_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] in_data,
  output logic             in_ready,
  output logic [15:0]      bcd,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   cap_q, cap_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic               cap_over;

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Compare the untouched captured value; bin_q has been shifted away by COMMIT.
  assign cap_over = 32'(cap_q) > MAX_DEC;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cap_d     = cap_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          bin_d     = in_data;
          cap_d     = in_data;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = COMMIT;
      end
      COMMIT: begin
        if (cap_over) begin
          bcd_d = SAT_BCD;
          ovf_d = 1'b1;
        end else begin
          bcd_d = scratch_q;
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      cap_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      cap_q     <= cap_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seg7_bcd_ctrl.sv
// Directed bench for seg7_bcd_ctrl: a BIN_W=14 instance plus a BIN_W=8 instance.
module tb_seg7_bcd_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_ready, overflow, busy, done;
  logic [15:0] bcd;

  logic        in_valid8 = 1'b0;
  logic [7:0]  in_data8 = '0;
  logic        in_ready8, overflow8, busy8, done8;
  logic [15:0] bcd8;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_bcd = 16'h0000;

  always #5 clock = ~clock;

  seg7_bcd_ctrl #(.BIN_W(14)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bcd(bcd), .overflow(overflow), .busy(busy), .done(done)
  );

  seg7_bcd_ctrl #(.BIN_W(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .bcd(bcd8), .overflow(overflow8), .busy(busy8), .done(done8)
  );

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid8 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bcd8 !== 16'h0000 || in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_w8 got bcd=%h rdy=%b want 0000/1", bcd8, in_ready8); end
    prev_bcd = 16'h0000;
  endtask

  task automatic test_normal();
    logic [13:0] vals [5];
    logic [15:0] exps [5];
    logic        ovfs [5];
    logic        bad;
    vals = '{14'd1234, 14'd0, 14'd9999, 14'd10000, 14'd42};
    exps = '{16'h1234, 16'h0000, 16'h9999, 16'h9999, 16'h0042};
    ovfs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = vals[k];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL conv_ready[%0d] got %b want 1", k, in_ready); end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL conv_busy[%0d] got busy=%b rdy=%b want 1/0", k, busy, in_ready); end
      bad = 1'b0;
      for (int c = 1; c < 15; c++) begin
        @(posedge clock); #1;
        if (bcd !== prev_bcd || done !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL conv_hold[%0d] got bcd=%h done=%b want %h/0", k, bcd, done, prev_bcd); end
      @(posedge clock); #1;
      checks++; if (bcd !== exps[k]) begin errors++; $display("FAIL conv_bcd[%0d] got %h want %h", k, bcd, exps[k]); end
      checks++; if (overflow !== ovfs[k]) begin errors++; $display("FAIL conv_ovf[%0d] got %b want %b", k, overflow, ovfs[k]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL conv_done[%0d] got %b want 1", k, done); end
      @(posedge clock); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL conv_idle[%0d] got done=%b busy=%b rdy=%b want 0/0/1", k, done, busy, in_ready); end
      prev_bcd = exps[k];
    end
  endtask

  task automatic test_back_to_back();
    logic bad;
    in_valid = 1'b1;
    in_data  = 14'd567;
    @(posedge clock); #1;
    in_data = 14'd8888;
    bad = 1'b0;
    for (int c = 1; c < 15; c++) begin
      if (in_ready !== 1'b0 || bcd !== prev_bcd) bad = 1'b1;
      @(posedge clock); #1;
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_ignore got rdy=%b bcd=%h want 0/%h", in_ready, bcd, prev_bcd); end
    @(posedge clock); #1;
    checks++; if (bcd !== 16'h0567) begin errors++; $display("FAIL b2b_first got %h want 0567", bcd); end
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle got done=%b rdy=%b want 1/1", done, in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || bcd !== 16'h0567) begin errors++; $display("FAIL b2b_accept got busy=%b bcd=%h want 1/0567", busy, bcd); end
    repeat (14) @(posedge clock);
    #1;
    checks++; if (bcd !== 16'h0567 || done !== 1'b0) begin errors++; $display("FAIL b2b_early got bcd=%h done=%b want 0567/0", bcd, done); end
    @(posedge clock); #1;
    checks++; if (bcd !== 16'h8888 || done !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_second got bcd=%h done=%b ovf=%b want 8888/1/0", bcd, done, overflow); end
    @(posedge clock); #1;
    prev_bcd = 16'h8888;
  endtask

  task automatic test_reset_mid();
    logic bad;
    in_valid = 1'b1;
    in_data  = 14'd4321;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bcd !== 16'h0000 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_bcd got bcd=%h ovf=%b want 0000/0", bcd, overflow); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got busy=%b rdy=%b want 0/1", busy, in_ready); end
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0 || bcd !== 16'h0000) bad = 1'b1;
      @(posedge clock); #1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rmid_nodone got done=%b bcd=%h want 0/0000", done, bcd); end
    in_valid = 1'b1;
    in_data  = 14'd77;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    checks++; if (bcd !== 16'h0077 || done !== 1'b1) begin errors++; $display("FAIL rmid_after got bcd=%h done=%b want 0077/1", bcd, done); end
    @(posedge clock); #1;
  endtask

  task automatic test_width8();
    logic bad;
    in_valid8 = 1'b1;
    in_data8  = 8'd255;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL w8_busy got %b want 1", busy8); end
    bad = 1'b0;
    for (int c = 1; c < 9; c++) begin
      @(posedge clock); #1;
      if (bcd8 !== 16'h0000 || done8 !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL w8_hold got bcd=%h done=%b want 0000/0", bcd8, done8); end
    @(posedge clock); #1;
    checks++; if (bcd8 !== 16'h0255) begin errors++; $display("FAIL w8_bcd got %h want 0255", bcd8); end
    checks++; if (overflow8 !== 1'b0 || done8 !== 1'b1) begin errors++; $display("FAIL w8_flags got ovf=%b done=%b want 0/1", overflow8, done8); end
    @(posedge clock); #1;
    checks++; if (done8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL w8_idle got done=%b rdy=%b want 0/1", done8, in_ready8); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_ctrl.md
Name: seg7_bcd_ctrl

Overview:
Sequential binary-to-BCD controller that feeds the 16-bit packed BCD bus of the four-digit seven-segment decoder. It accepts a binary value from the processor datapath over a valid/ready handshake and converts it with a multi-cycle shift-add-3 (double-dabble) sequence. It holds the result stable on `bcd` until the next conversion commits, so the display never shows intermediate digits. Values above 9999 saturate to 9999 and raise an overflow flag.

Parameters:
- BIN_W, 14, width of the binary input; legal range 4..16.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is valid this cycle
- in_data  in  BIN_W  unsigned binary value to display
- in_ready  out  1  controller can accept a value this cycle
- bcd  out  16  packed BCD to the decoder: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands; registered
- overflow  out  1  last committed value exceeded 9999; registered
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse after a commit

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, bcd=16'h0000, overflow=0, done=0, busy=0, in_ready=1. Shift and scratch registers are cleared.
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - in_ready=1, busy=0.
  - On a clock edge with in_valid=1: capture in_data into the binary shift register, clear the 16-bit scratch BCD, set cnt=0, and go to CONV.
- CONV:
  - in_ready=0, busy=1. Each edge performs one iteration:
    - every scratch nibble >= 5 gets +3 (per-nibble, 4-bit arithmetic);
    - then {scratch, binreg} shifts left by 1 (binreg MSB enters scratch[0]);
    - cnt increments.
  - When cnt = BIN_W-1 on an edge, that edge does the last iteration and the state goes to COMMIT.
  - Scratch is exactly 16 bits. Bits shifted out of scratch[15] are discarded.
- COMMIT:
  - busy=1, in_ready=0.
  - On the edge: if the captured value > 9999, then bcd=16'h9999 and overflow=1; else bcd=scratch and overflow=0.
  - Same edge: done registered to 1, state goes to IDLE.
- Latency: value accepted at edge N; bcd/overflow update at edge N+BIN_W+1. done is high for exactly the one cycle after that edge. Throughput is one value per BIN_W+2 cycles.
- in_valid while not IDLE is ignored (no queuing). The source must hold until in_ready.
- An accept is allowed in the same cycle that done is high, because the state is already IDLE.
- bcd and overflow change only at a COMMIT edge or at reset. They never show partial results.
- The captured value used for the overflow compare is held in a dedicated BIN_W register, not the shifted one.
- If BIN_W <= 13, the overflow compare is constant-false and may be optimized away.
- Reset mid-conversion (CONV or COMMIT): abort, discard the value, and apply the reset values on that edge. No done pulse.
- in_data is sampled only on the accept edge. Later changes have no effect.

Decomposition:
- Shared package seg7_pkg:
  - state enum (IDLE, CONV, COMMIT);
  - MAX_DEC = 9999;
  - SAT_BCD = 16'h9999;
  - BCD_W = 16.
- One natural sub-module: bcd_digit_adj, the combinational 4-bit "if >= 5 add 3" cell, instantiated four times.

Test Plan (BIN_W=14 unless stated):
- Reset: assert reset 2 cycles -> bcd=16'h0000, overflow=0, in_ready=1, busy=0, done=0.
- Normal conversion: in_data=1234 accepted at edge N -> busy=1 from N; bcd=16'h1234 at edge N+15; done high one cycle; overflow=0. Repeat with 0 -> 16'h0000 and 9999 -> 16'h9999, overflow=0.
- Saturation: in_data=10000 -> bcd=16'h9999, overflow=1. Next in_data=42 -> bcd=16'h0042, overflow=0.
- Busy handling: accept 567, then drive in_valid=1 with in_data=8888 during CONV -> in_ready=0, 8888 ignored, bcd=16'h0567. Holding in_valid with 8888 is accepted in the done cycle -> bcd=16'h8888 at 16 edges later.
- Reset mid-operation: accept 4321, assert reset at cnt=7 -> bcd=16'h0000, no done pulse, state IDLE next cycle. New value 77 -> bcd=16'h0077.
- BIN_W=8: in_data=255 -> bcd=16'h0255 at edge N+9; overflow never set.
